// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS phase-config AXI-Stream slave.
// Steps phase_inc from start to stop at a fixed dwell; single, sawtooth or triangle.
//   state  | meaning
//   IDLE   | waiting for start
//   STEP   | issue first beat of a sweep
//   DWELL  | counting down between beats, then step/turn/finish
//   FINISH | done pulse cycle, back to IDLE
module dds_sweep_ctrl #(
  parameter int PHASE_W = 32,
  parameter int DWELL_W = 16
) (
  input  logic                   clk163m84,
  input  logic                   rst,
  input  logic [PHASE_W-1:0]     cfg_start_inc,
  input  logic [PHASE_W-1:0]     cfg_stop_inc,
  input  logic [PHASE_W-1:0]     cfg_step,
  input  logic [DWELL_W-1:0]     cfg_dwell,
  input  logic [1:0]             cfg_mode,
  input  logic [PHASE_W-1:0]     cfg_phase_off,
  input  logic                   start,
  input  logic                   stop,
  output logic                   phase_tvalid,
  output logic [2*PHASE_W-1:0]   phase_tdata,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            sweep_cnt
);

  typedef enum logic [1:0] {IDLE, STEP, DWELL, FINISH} state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   start_q, start_d, stop_q, stop_d, step_q, step_d, off_q, off_d;
  logic [PHASE_W-1:0]   cur_q, cur_d;
  logic [DWELL_W-1:0]   dly_q, dly_d, cnt_q, cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic                 rev_q, rev_d;
  logic                 tvalid_d, busy_d, done_d;
  logic [2*PHASE_W-1:0] tdata_d;
  logic [15:0]          sweep_d;
  logic [PHASE_W-1:0]   tgt, tgt_turn, beat_val;

  // One step from c toward t, clamped to t on overshoot, carry or borrow.
  function automatic logic [PHASE_W-1:0] step_to(input logic [PHASE_W-1:0] c,
                                                 input logic [PHASE_W-1:0] t,
                                                 input logic [PHASE_W-1:0] s);
    logic [PHASE_W:0] r;
    logic [PHASE_W-1:0] res;
    res = t;
    if (t >= c) begin
      r = {1'b0, c} + {1'b0, s};
      if (!r[PHASE_W] && r[PHASE_W-1:0] <= t) res = r[PHASE_W-1:0];
    end else begin
      r = {1'b0, c} - {1'b0, s};
      if (!r[PHASE_W] && r[PHASE_W-1:0] >= t) res = r[PHASE_W-1:0];
    end
    return res;
  endfunction

  assign tgt      = rev_q ? start_q : stop_q;
  assign tgt_turn = rev_q ? stop_q  : start_q;

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    off_d    = off_q;
    dly_d    = dly_q;
    mode_d   = mode_q;
    cur_d    = cur_q;
    rev_d    = rev_q;
    cnt_d    = cnt_q;
    tvalid_d = 1'b0;
    tdata_d  = phase_tdata;
    busy_d   = busy;
    done_d   = 1'b0;
    sweep_d  = sweep_cnt;
    beat_val = step_to(cur_q, tgt, step_q);

    if (stop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, FINISH: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (start) begin
            start_d = cfg_start_inc;
            stop_d  = cfg_stop_inc;
            step_d  = cfg_step;
            off_d   = cfg_phase_off;
            mode_d  = cfg_mode;
            dly_d   = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
            cur_d   = cfg_start_inc;
            rev_d   = 1'b0;
            sweep_d = '0;
            state_d = STEP;
          end
        end
        STEP: begin
          tvalid_d = 1'b1;
          tdata_d  = {off_q, cur_q};
          busy_d   = 1'b1;
          cnt_d    = dly_q;
          state_d  = DWELL;
        end
        DWELL: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_W'(1);
          end else if (step_q == '0 || (cur_q == tgt && mode_q != 2'd1 && mode_q != 2'd2)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FINISH;
          end else begin
            if (cur_q == tgt) begin
              if (sweep_cnt != 16'hFFFF) sweep_d = sweep_cnt + 16'd1;
              if (mode_q == 2'd1) begin
                beat_val = start_q;
              end else begin
                rev_d    = ~rev_q;
                beat_val = step_to(cur_q, tgt_turn, step_q);
              end
            end
            cur_d    = beat_val;
            tvalid_d = 1'b1;
            tdata_d  = {off_q, beat_val};
            cnt_d    = dly_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk163m84) begin
    if (rst) begin
      state_q      <= IDLE;
      start_q      <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      off_q        <= '0;
      dly_q        <= '0;
      mode_q       <= '0;
      cur_q        <= '0;
      rev_q        <= 1'b0;
      cnt_q        <= '0;
      phase_tvalid <= 1'b0;
      phase_tdata  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sweep_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      off_q        <= off_d;
      dly_q        <= dly_d;
      mode_q       <= mode_d;
      cur_q        <= cur_d;
      rev_q        <= rev_d;
      cnt_q        <= cnt_d;
      phase_tvalid <= tvalid_d;
      phase_tdata  <= tdata_d;
      busy         <= busy_d;
      done         <= done_d;
      sweep_cnt    <= sweep_d;
    end
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Frequency-sweep sequencer for the DDS compiler phase-config AXI-Stream slave in the 163.84 MHz DAC domain.
- Steps phase_inc from a start value to a stop value at a fixed dwell.
- Emits one single-cycle phase_tvalid beat per frequency point, with phase_tdata packed {phase_off, phase_inc}.
- Supports single-shot, sawtooth-repeat and triangle modes; replaces hand-poking of phase_inc/phase_off and tvalid from the VIO.

Parameters:
- PHASE_W, 32, width of phase_inc and phase_off.
- DWELL_W, 16, width of the dwell counter.

Ports:
- clk163m84  in  1  DDS/DAC clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- cfg_start_inc  in  PHASE_W  first phase increment.
- cfg_stop_inc  in  PHASE_W  last phase increment.
- cfg_step  in  PHASE_W  unsigned step magnitude.
- cfg_dwell  in  DWELL_W  cycles between beats; 0 is treated as 1.
- cfg_mode  in  2  0 single, 1 sawtooth repeat, 2 triangle, 3 same as 0.
- cfg_phase_off  in  PHASE_W  constant phase offset.
- start  in  1  one-cycle start request.
- stop  in  1  one-cycle abort request.
- phase_tvalid  out  1  one-cycle beat to the DDS s_axis_phase_tvalid.
- phase_tdata  out  2*PHASE_W  {phase_off, phase_inc}.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse on normal completion.
- sweep_cnt  out  16  number of endpoint turns or wraps since start.

Behaviour:
- Reset values: phase_tvalid=0, phase_tdata=0, busy=0, done=0, sweep_cnt=0, state IDLE. Reset mid-sweep aborts at the next edge with no done pulse.
- States: IDLE, DWELL, STEP, FINISH. All outputs are registered.
- Start from IDLE:
  - start sampled high at edge n latches all cfg_* inputs. Inputs are ignored afterwards until the next start.
  - At edge n+1: phase_tdata={cfg_phase_off, cfg_start_inc}, phase_tvalid=1 for exactly one cycle, busy=1, sweep_cnt=0.
- Start while busy: ignored.
- Stop:
  - stop has priority over start in the same cycle.
  - In any state, the next state is IDLE with busy=0, phase_tvalid=0 and no done pulse.
  - phase_tdata holds its last value.
- Beat spacing: after each beat the controller waits D cycles, where D=max(cfg_dwell,1). Beats occur at cycles t0, t0+D, t0+2D, and so on. The DDS has no backpressure, so tvalid carries no ready handshake.
- Direction:
  - Up if stop>=start (unsigned), else down.
  - Next value is computed with PHASE_W+1 bits.
  - Up: next=cur+step. If next>stop or carry, clamp to stop.
  - Down: next=cur-step. If next<stop or borrow, clamp to stop.
  - In triangle mode the roles of start and stop swap after each turn.
- Endpoint reached (current value equals the target, after its dwell):
  - mode 0/3: go to FINISH. done=1 for one cycle, busy=0, return to IDLE. Last phase_inc is held; no extra beat.
  - mode 1: sweep_cnt++ and the next beat reissues cfg_start_inc.
  - mode 2: sweep_cnt++, reverse direction, and the next beat is the endpoint stepped back by step (clamped).
- cfg_step==0: single tone. One beat of start_inc, then after D cycles done, in all modes.
- start==stop with step!=0:
  - mode 0: one beat, then done after D cycles.
  - modes 1/2: the same value is re-beaten every D cycles and sweep_cnt increments each time.
- sweep_cnt saturates at 0xFFFF.

Test Plan:
- start=100, stop=130, step=10, dwell=4, mode 0, start pulsed at cycle 0 -> beats at cycles 1,5,9,13 carrying inc 100,110,120,130; done at 17; busy low from 17.
- start=100, stop=125, step=10, dwell=1, mode 0 -> inc sequence 100,110,120,125 on consecutive cycles (clamp); phase_off field equals cfg_phase_off on every beat.
- start=0x8000, stop=0x7FF0, step=8, mode 1, dwell=2 -> 8000,7FF8,7FF0,8000,...; sweep_cnt=1 at the second 8000 beat.
- start=0, stop=20, step=10, dwell=2, mode 2 -> 0,10,20,10,0,10; sweep_cnt increments after the 20 beat and after the 0 beat.
- start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20 -> beats F0 then FFFFFFFF (carry clamp); cfg_dwell=0 behaves as dwell 1.
- Stop mid-sweep, start+stop in the same cycle, rst mid-sweep, step=0 -> IDLE with no done pulse and tdata held for the aborts; step=0 gives one beat then done.
